// File: rtl/vw_blend_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vw_blend_pkg
// Shared register map, FSM states, STATUS layout and the saturating blend.
// Revision : 1.0
// ----------------------------------------------------------------------------
package vw_blend_pkg;

  localparam int unsigned ADDR_CTRL   = 32'h0;
  localparam int unsigned ADDR_ALPHA  = 32'h1;
  localparam int unsigned ADDR_BETA   = 32'h2;
  localparam int unsigned ADDR_PIXCNT = 32'h3;
  localparam int unsigned ADDR_STATUS = 32'h4;
  localparam int unsigned ADDR_PUSH   = 32'h8;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_BYPASS = 1;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_OVF     = 1;
  localparam int unsigned STAT_SAT     = 2;
  localparam int unsigned STAT_LVL_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic        clip;
    logic [31:0] value;
  } blend_t;

  // Scale the weighted sum back to sample range and clip at full scale.
  function automatic blend_t sat_blend(input logic [31:0] sum, input int unsigned dd);
    blend_t      r;
    logic [31:0] shifted;
    logic [31:0] max_v;
    shifted = sum >> dd;
    max_v   = (32'd1 << dd) - 32'd1;
    r.clip  = (shifted > max_v);
    r.value = r.clip ? max_v : shifted;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vw_blend_engine_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vw_blend_engine_if
// APB slave bus bundle for the blend engine.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface vw_blend_engine_if #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20
);
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [Amba_Word-1:0]       PWDATA;
  logic [Amba_Addr_Depth-1:0] PADDR;
  logic [Amba_Word-1:0]       PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PWDATA, PADDR, input PRDATA);
  modport slave  (input PSEL, PENABLE, PWRITE, PWDATA, PADDR, output PRDATA);
endinterface
`default_nettype wire

// File: rtl/vw_pair_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vw_pair_fifo
// Synchronous FIFO holding host/watermark sample pairs.
// Revision : 1.0
// ----------------------------------------------------------------------------
module vw_pair_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_AW-1:0]  wptr_q;
  logic [c_AW-1:0]  rptr_q;
  logic [c_AW:0]    level_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (level_q == c_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (w_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (w_pop) rptr_q <= rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/vw_blend_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vw_blend_engine
// APB-configured alpha/beta blender streaming multi-channel pixels.
// Revision : 1.0
// ----------------------------------------------------------------------------
module vw_blend_engine
  import vw_blend_pkg::*;
#(
  parameter int Data_Depth      = 8,
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int Num_Channels    = 3,
  parameter int Fifo_Depth      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  vw_blend_engine_if.slave                   apb,
  output logic [Num_Channels*Data_Depth-1:0] Pixel_Data,
  output logic                               new_pixel,
  output logic                               Image_Done
);
  localparam int c_DD = Data_Depth;
  localparam int c_PW = 2*Data_Depth+1;
  localparam int c_LW = $clog2(Fifo_Depth)+1;
  localparam int c_XW = Num_Channels*Data_Depth;

  localparam logic [Amba_Addr_Depth-1:0] c_A_CTRL   = Amba_Addr_Depth'(ADDR_CTRL);
  localparam logic [Amba_Addr_Depth-1:0] c_A_ALPHA  = Amba_Addr_Depth'(ADDR_ALPHA);
  localparam logic [Amba_Addr_Depth-1:0] c_A_BETA   = Amba_Addr_Depth'(ADDR_BETA);
  localparam logic [Amba_Addr_Depth-1:0] c_A_PIXCNT = Amba_Addr_Depth'(ADDR_PIXCNT);
  localparam logic [Amba_Addr_Depth-1:0] c_A_STATUS = Amba_Addr_Depth'(ADDR_STATUS);
  localparam logic [Amba_Addr_Depth-1:0] c_A_PUSH   = Amba_Addr_Depth'(ADDR_PUSH);

  state_e            state_q, state_d;
  logic              bypass_q;
  logic [c_DD:0]     alpha_q, beta_q;
  logic [15:0]       pix_cnt_q;
  logic              ovf_q, sat_q;

  logic [1:0]        pch_q;
  logic [15:0]       ppix_q;
  logic              pdone_q;

  logic              s1_vld_q, s1_lastch_q, s1_lastpix_q;
  logic [1:0]        s1_ch_q;
  logic [c_PW-1:0]   s1_pa_q, s1_pb_q;
  logic [c_DD-1:0]   s1_host_q;

  logic [c_XW-1:0]   asm_q, pix_q;
  logic              new_pixel_q, done_q;

  logic              w_wr, w_rd, w_start, w_push_req, w_pop, w_busy;
  logic              w_full, w_empty, w_pop_lastch, w_pop_lastpix;
  logic [c_LW-1:0]   w_level;
  logic [2*c_DD-1:0] w_pair;
  logic [c_DD-1:0]   w_host, w_wm, w_val;
  logic [31:0]       w_sum;
  blend_t            w_bl;
  logic              w_clip;
  logic [c_XW-1:0]   w_asm;
  logic [Amba_Word-1:0] w_rdata;
  logic              w_unused;

  assign w_wr       = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign w_rd       = apb.PSEL & ~apb.PWRITE;
  assign w_push_req = w_wr & (apb.PADDR == c_A_PUSH);
  assign w_start    = w_wr & (apb.PADDR == c_A_CTRL) & apb.PWDATA[CTRL_START]
                    & (state_q == ST_IDLE) & (pix_cnt_q != 16'd0);

  vw_pair_fifo #(
    .WIDTH (2*Data_Depth),
    .DEPTH (Fifo_Depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push_req),
    .pop_i   (w_pop),
    .wdata_i (apb.PWDATA[2*c_DD-1:0]),
    .rdata_o (w_pair),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  assign w_host        = w_pair[c_DD-1:0];
  assign w_wm          = w_pair[2*c_DD-1:c_DD];
  assign w_pop_lastch  = (pch_q == 2'(Num_Channels-1));
  assign w_pop_lastpix = (ppix_q == pix_cnt_q - 16'd1);

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_start) state_d = ST_RUN;
      ST_RUN:  if (s1_vld_q & s1_lastch_q & s1_lastpix_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Popping stops once the final pair is in the pipeline.
  always_comb begin
    w_busy = (state_q != ST_IDLE);
    w_pop  = (state_q == ST_RUN) & ~pdone_q & ~w_empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bypass_q  <= 1'b0;
      alpha_q   <= '0;
      beta_q    <= '0;
      pix_cnt_q <= '0;
      ovf_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      if (w_wr) begin
        if (apb.PADDR == c_A_CTRL)   bypass_q  <= apb.PWDATA[CTRL_BYPASS];
        if (apb.PADDR == c_A_ALPHA)  alpha_q   <= apb.PWDATA[c_DD:0];
        if (apb.PADDR == c_A_BETA)   beta_q    <= apb.PWDATA[c_DD:0];
        if (apb.PADDR == c_A_PIXCNT) pix_cnt_q <= apb.PWDATA[15:0];
      end
      if (w_start)                              ovf_q <= 1'b0;
      else if (w_push_req & w_full & ~w_pop)    ovf_q <= 1'b1;
      if (w_start)                              sat_q <= 1'b0;
      else if (s1_vld_q & w_clip)               sat_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pch_q   <= '0;
      ppix_q  <= '0;
      pdone_q <= 1'b0;
    end else if (w_start) begin
      pch_q   <= '0;
      ppix_q  <= '0;
      pdone_q <= 1'b0;
    end else if (w_pop) begin
      if (w_pop_lastch) begin
        pch_q <= '0;
        if (w_pop_lastpix) pdone_q <= 1'b1;
        else               ppix_q  <= ppix_q + 16'd1;
      end else begin
        pch_q <= pch_q + 2'd1;
      end
    end
  end

  // Stage 1: weighted products
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q     <= 1'b0;
      s1_lastch_q  <= 1'b0;
      s1_lastpix_q <= 1'b0;
      s1_ch_q      <= '0;
      s1_pa_q      <= '0;
      s1_pb_q      <= '0;
      s1_host_q    <= '0;
    end else begin
      s1_vld_q <= w_pop;
      if (w_pop) begin
        s1_lastch_q  <= w_pop_lastch;
        s1_lastpix_q <= w_pop_lastch & w_pop_lastpix;
        s1_ch_q      <= pch_q;
        s1_pa_q      <= c_PW'(alpha_q) * c_PW'(w_host);
        s1_pb_q      <= c_PW'(beta_q) * c_PW'(w_wm);
        s1_host_q    <= w_host;
      end
    end
  end

  // Stage 2: sum, scale, saturate and drop into the channel slot
  assign w_sum  = 32'(s1_pa_q) + 32'(s1_pb_q);
  assign w_bl   = sat_blend(w_sum, Data_Depth);
  assign w_val  = bypass_q ? s1_host_q : w_bl.value[c_DD-1:0];
  assign w_clip = ~bypass_q & w_bl.clip;

  always_comb begin
    w_asm = asm_q;
    for (int c = 0; c < Num_Channels; c++) begin
      if (s1_ch_q == 2'(c)) w_asm[c*c_DD +: c_DD] = w_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q       <= '0;
      pix_q       <= '0;
      new_pixel_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      new_pixel_q <= 1'b0;
      done_q      <= 1'b0;
      if (s1_vld_q) begin
        asm_q <= w_asm;
        if (s1_lastch_q) begin
          pix_q       <= w_asm;
          new_pixel_q <= 1'b1;
          done_q      <= s1_lastpix_q;
        end
      end
    end
  end

  assign Pixel_Data = pix_q;
  assign new_pixel  = new_pixel_q;
  assign Image_Done = done_q;

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      if (apb.PADDR == c_A_CTRL)   w_rdata[CTRL_BYPASS] = bypass_q;
      if (apb.PADDR == c_A_ALPHA)  w_rdata[c_DD:0]      = alpha_q;
      if (apb.PADDR == c_A_BETA)   w_rdata[c_DD:0]      = beta_q;
      if (apb.PADDR == c_A_PIXCNT) w_rdata[15:0]        = pix_cnt_q;
      if (apb.PADDR == c_A_STATUS) begin
        w_rdata[STAT_BUSY]            = w_busy;
        w_rdata[STAT_OVF]             = ovf_q;
        w_rdata[STAT_SAT]             = sat_q;
        w_rdata[STAT_LVL_LSB +: 4]    = 4'(w_level);
      end
    end
  end

  assign apb.PRDATA = w_rdata;
  assign w_unused   = ^{apb.PWDATA, w_bl.value};

endmodule
`default_nettype wire

// File: tb/tb_vw_blend_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_vw_blend_engine
// Self-checking bench: directed scenarios plus randomized runs vs. a reference.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_vw_blend_engine;
  localparam int DD  = 8;
  localparam int NCH = 3;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vw_blend_engine_if #(.Amba_Word(16), .Amba_Addr_Depth(20)) apb();
  logic [NCH*DD-1:0] Pixel_Data;
  logic              new_pixel;
  logic              Image_Done;

  vw_blend_engine #(
    .Data_Depth(DD), .Amba_Word(16), .Amba_Addr_Depth(20),
    .Num_Channels(NCH), .Fifo_Depth(FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .apb        (apb),
    .Pixel_Data (Pixel_Data),
    .new_pixel  (new_pixel),
    .Image_Done (Image_Done)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor
  logic [NCH*DD-1:0] got_pix[$];
  bit                got_done[$];
  int                got_cyc[$];
  always @(negedge clk) begin
    if (new_pixel) begin
      got_pix.push_back(Pixel_Data);
      got_done.push_back(Image_Done);
      got_cyc.push_back(cyc);
    end else if (Image_Done) begin
      chk("done_with_pixel", {31'd0, new_pixel}, 32'd1);
    end
  end

  // Reference model: pairs not yet consumed, in arrival order, as {wm, host}
  logic [15:0] mq[$];
  int cur_a, cur_b, cur_np;
  bit cur_byp;

  function automatic logic [8:0] ref_blend(input int a, input int b, input int h,
                                           input int w, input bit byp);
    int s;
    if (byp) return {1'b0, 8'(h)};
    s = (a * h + b * w) / (1 << DD);
    if (s > (1 << DD) - 1) return {1'b1, 8'hFF};
    return {1'b0, 8'(s)};
  endfunction

  task automatic apb_wr(input logic [19:0] a, input logic [15:0] d, output int xc);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d; apb.PENABLE = 1'b0;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1; xc = cyc;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic reg_wr(input logic [19:0] a, input logic [15:0] d);
    int xc;
    apb_wr(a, d, xc);
  endtask

  task automatic apb_rd(input logic [19:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = a; apb.PENABLE = 1'b0;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    #1 d = apb.PRDATA;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic push(input int h, input int w, output int xc);
    apb_wr(20'h8, {8'(w), 8'(h)}, xc);
    mq.push_back({8'(w), 8'(h)});
  endtask

  task automatic push_rand(output int xc);
    push($urandom_range(0, 255), $urandom_range(0, 255), xc);
  endtask

  task automatic cfg(input int a, input int b, input int np, input bit byp);
    cur_a = a; cur_b = b; cur_np = np; cur_byp = byp;
    reg_wr(20'h1, 16'(a));
    reg_wr(20'h2, 16'(b));
    reg_wr(20'h3, 16'(np));
    reg_wr(20'h0, {14'd0, byp, 1'b0});
  endtask

  task automatic start(output int xc);
    apb_wr(20'h0, {14'd0, cur_byp, 1'b1}, xc);
  endtask

  task automatic wait_img(input string tag);
    int t = 0;
    while (got_pix.size() < cur_np && t < 2000) begin
      @(posedge clk); t++;
    end
    repeat (4) @(posedge clk);
    chk({tag, "_strobes"}, got_pix.size(), cur_np);
  endtask

  // Compare captured strobes against the model; consumes NCH*np model pairs.
  task automatic check_img(input string tag, output bit any_clip);
    logic [NCH*DD-1:0] e;
    logic [8:0]        r;
    logic [15:0]       pr;
    any_clip = 1'b0;
    for (int p = 0; p < cur_np; p++) begin
      e = '0;
      for (int c = 0; c < NCH; c++) begin
        pr = (mq.size() > 0) ? mq.pop_front() : 16'd0;
        r  = ref_blend(cur_a, cur_b, pr[7:0], pr[15:8], cur_byp);
        e  = e | ((NCH*DD)'(r[7:0]) << (DD * c));
        any_clip = any_clip | r[8];
      end
      if (p < got_pix.size()) begin
        chk($sformatf("%s_pix%0d", tag, p), got_pix[p], e);
        chk($sformatf("%s_done%0d", tag, p), {31'd0, got_done[p]}, {31'd0, p == cur_np - 1});
      end
    end
    got_pix.delete(); got_done.delete(); got_cyc.delete();
  endtask

  task automatic rand_run(input int idx);
    int need, pre, xc;
    bit clip;
    logic [15:0] st;
    cfg($urandom_range(0, 256), $urandom_range(0, 256), $urandom_range(1, 4),
        ($urandom_range(0, 3) == 0));
    need = NCH * cur_np - mq.size();
    pre  = (need < FD - mq.size()) ? need : FD - mq.size();
    for (int i = 0; i < pre; i++) push_rand(xc);
    start(xc);
    for (int i = pre; i < need; i++) push_rand(xc);
    wait_img($sformatf("rnd%0d", idx));
    check_img($sformatf("rnd%0d", idx), clip);
    apb_rd(20'h4, st);
    chk($sformatf("rnd%0d_status", idx), st, {13'd0, clip, 2'b00});
  endtask

  initial begin : stim
    logic [15:0] rd;
    int          xc, sxc;
    int          pc[6];
    bit          clip;

    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PWDATA = '0; apb.PADDR = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixel", Pixel_Data, 0);
    chk("rst_strobe", {30'd0, new_pixel, Image_Done}, 0);
    rst = 1'b1;
    apb_rd(20'h4, rd); chk("rst_status", rd, 0);
    apb_rd(20'h1, rd); chk("rst_alpha", rd, 0);
    apb_rd(20'h3, rd); chk("rst_pixcnt", rd, 0);

    // Directed blend
    cfg(128, 128, 1, 1'b0);
    apb_rd(20'h1, rd); chk("alpha_rb", rd, 128);
    push(100, 200, xc); push(0, 255, xc); push(255, 255, xc);
    start(sxc);
    wait_img("blend");
    if (got_pix.size() > 0) begin
      chk("blend_const", got_pix[0], 24'hFF7F96);
      chk("blend_latency", got_cyc[0], sxc + 5);
    end
    check_img("blend", clip);
    apb_rd(20'h4, rd); chk("blend_status", rd, 0);

    // Saturation, then cleared by the next START
    cfg(256, 256, 1, 1'b0);
    push(200, 100, xc); push(1, 2, xc); push(3, 4, xc);
    start(xc);
    wait_img("sat");
    check_img("sat", clip);
    apb_rd(20'h4, rd); chk("sat_set", rd, 16'h0004);
    cfg(16, 32, 1, 1'b0);
    push(10, 20, xc); push(30, 40, xc); push(50, 60, xc);
    start(xc);
    wait_img("satclr");
    check_img("satclr", clip);
    apb_rd(20'h4, rd); chk("sat_cleared", rd, 0);

    // Overflow while idle
    cfg(128, 64, 1, 1'b0);
    for (int i = 0; i < 5; i++) push_rand(xc);
    void'(mq.pop_back());
    apb_rd(20'h4, rd); chk("ovf_status", rd, 16'h0042);
    start(xc);
    wait_img("ovf");
    check_img("ovf", clip);
    apb_rd(20'h4, rd); chk("ovf_after", rd, {13'd0, clip, 2'b00} | 16'h0010);

    rand_run(0);
    rand_run(1);

    // Bypass
    cfg(77, 99, 2, 1'b1);
    for (int i = 1; i <= 4; i++) push(i, $urandom_range(0, 255), xc);
    start(xc);
    push(5, 0, xc); push(6, 255, xc);
    wait_img("byp");
    if (got_pix.size() == 2) begin
      chk("byp_px0", got_pix[0], 24'h030201);
      chk("byp_px1", got_pix[1], 24'h060504);
    end
    check_img("byp", clip);

    // Starved stream with an ignored START mid-run
    cfg($urandom_range(0, 256), $urandom_range(0, 256), 2, 1'b0);
    start(xc);
    for (int i = 0; i < 6; i++) begin
      push_rand(pc[i]);
      if (i == 3) reg_wr(20'h0, 16'h0001);
      repeat (7) @(posedge clk);
    end
    wait_img("starve");
    if (got_cyc.size() == 2) begin
      chk("starve_lat0", got_cyc[0], pc[2] + 3);
      chk("starve_lat1", got_cyc[1], pc[5] + 3);
    end
    check_img("starve", clip);
    apb_rd(20'h4, rd); chk("starve_status", rd, {13'd0, clip, 2'b00});

    // Reset mid-run
    cfg(100, 100, 1, 1'b0);
    start(xc);
    push_rand(xc); push_rand(xc);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mrst_pixel", Pixel_Data, 0);
    chk("mrst_strobe", {30'd0, new_pixel, Image_Done}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mq.delete();
    repeat (10) @(posedge clk);
    chk("mrst_nostrobe", got_pix.size(), 0);
    apb_rd(20'h4, rd); chk("mrst_status", rd, 0);
    apb_rd(20'h2, rd); chk("mrst_beta", rd, 0);
    cfg(200, 50, 1, 1'b0);
    push_rand(xc); push_rand(xc); push_rand(xc);
    start(xc);
    wait_img("fresh");
    check_img("fresh", clip);

    for (int i = 2; i < 8; i++) rand_run(i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/vw_blend_engine.md
Name: vw_blend_engine

Overview:
- Parametrised successor of the Visible_Watermarking core.
- An APB-configured streaming blender: the host pushes host/watermark sample pairs over APB; each pair is blended as out = sat((alpha*host + beta*wm) >> Data_Depth).
- Samples are grouped into multi-channel pixels and streamed on Pixel_Data with a new_pixel strobe. Image_Done asserts after a programmed pixel count.
- Adds what the previous core lacks: a channel-count parameter, an input FIFO, a bypass mode and saturation/overflow status.

Parameters:
- Data_Depth, 8, bits per channel sample
- Amba_Word, 16, APB data width; must be >= 2*Data_Depth
- Amba_Addr_Depth, 20, APB address width
- Num_Channels, 3, channels per output pixel (1..4)
- Fifo_Depth, 4, pair FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable phase
- PWRITE  in  1  APB write
- PWDATA  in  Amba_Word  APB write data
- PADDR  in  Amba_Addr_Depth  APB address
- PRDATA  out  Amba_Word  APB read data
- Pixel_Data  out  Num_Channels*Data_Depth  blended pixel; channel 0 in the LSBs
- new_pixel  out  1  one-cycle strobe; Pixel_Data valid
- Image_Done  out  1  one-cycle strobe with the final pixel

Behaviour:
- Reset (rst=0, async): all registers are 0, FIFO empty, FSM in IDLE. PRDATA, Pixel_Data, new_pixel and Image_Done are 0.
- APB access: a transfer occurs on PSEL & PENABLE. There is no wait state. Reads return register values combinationally; unmapped reads return 0.
- Register map (word addresses):
  - 0x0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 BYPASS.
  - 0x1 ALPHA [Data_Depth:0].
  - 0x2 BETA [Data_Depth:0].
  - 0x3 PIX_CNT [15:0].
  - 0x4 STATUS (RO): bit0 busy, bit1 overflow (sticky, cleared on START), bit2 saturated (sticky, cleared on START), bits[7:4] FIFO level.
  - 0x8 PUSH (WO): host sample = PWDATA[Data_Depth-1:0]; watermark sample = PWDATA[2*Data_Depth-1:Data_Depth].
- PUSH handling:
  - When the FIFO is full, the write is dropped and overflow is set.
  - A PUSH in IDLE is still accepted into the FIFO (preload).
  - A simultaneous push and pop is allowed when full: the pop frees the slot and the push succeeds.
- FSM:
  - IDLE: on START with PIX_CNT != 0, go to RUN and clear the channel and pixel counters. START with PIX_CNT = 0 is ignored.
  - RUN: pop one pair per cycle while the FIFO is non-empty.
  - DONE: one cycle, then return to IDLE.
  - START while in RUN is ignored.
- Pipeline:
  - Stage 1 registers products alpha*host and beta*wm, each 2*Data_Depth+1 bits.
  - Stage 2 sums them, shifts right by Data_Depth, saturates to 2^Data_Depth-1 (setting saturated when clipping occurs), and writes the result into channel slot ch.
  - In BYPASS, stage 2 passes the host sample unchanged.
  - Latency: from the pop of the last channel of a pixel to new_pixel is 2 cycles.
- Channel and pixel counting:
  - When the channel counter wraps from Num_Channels-1 to 0, Pixel_Data is updated and new_pixel pulses.
  - On the pixel with index PIX_CNT-1, Image_Done pulses in the same cycle, the FSM enters DONE and popping stops.
  - Pairs left in the FIFO remain for the next START.
- Pixel_Data holds its last value between strobes.
- Reset mid-RUN: all state is lost immediately and no strobe is emitted.
- ALPHA/BETA writes during RUN take effect on the next pop. Software shall not do this.

Decomposition:
- Package vw_blend_pkg: register address localparams; FSM state enum (IDLE, RUN, DONE); STATUS bit positions; function sat_blend(sum).
- Sub-module vw_pair_fifo: parameterised sync FIFO (Fifo_Depth x 2*Data_Depth) with push, pop, full, empty, level.
- The top level holds the APB register bank, FSM, multiply pipeline and channel assembler.

Test Plan:
- Blend: Num_Channels=3, ALPHA=128, BETA=128, PIX_CNT=1; push (100,200), (0,255), (255,255), START -> 2 cycles after the 3rd pop, Pixel_Data={8'd255,8'd127,8'd150}, new_pixel=1 and Image_Done=1 together; saturated=0 (255*128+255*128=65280, >>8 = 255, no clip).
- Saturation: ALPHA=256, BETA=256, pair (200,100) -> channel value 255, STATUS.saturated=1; cleared by the next START.
- Overflow: with Fifo_Depth=4 and the FSM idle, push 5 pairs -> 5th dropped, STATUS level=4, overflow=1; START with PIX_CNT=1 and Num_Channels=3 -> 1 pair left, level=1.
- Bypass: BYPASS=1, PIX_CNT=2, push 6 pairs with host 1..6 -> two new_pixel strobes, Pixel_Data={3,2,1} then {6,5,4}; Image_Done only on the second strobe.
- Starved stream: START, then push pairs 10 cycles apart -> each pop occurs the cycle after its push and there are no spurious strobes; START issued during RUN has no effect.
- Reset mid-RUN: drop rst for 1 cycle after 2 pops -> outputs 0, STATUS=0, FSM IDLE; a fresh run then completes correctly.
